leaf_stream_drain: RTL and testbench

Downstream collector for the PE scheduling array: accepts 198-bit leaf-node matrices as the tree walk retires them, buffers them in a small FIFO, and serialises each one into a framed 32-bit stream for the host/DMA side. Each frame carries a header beat with the leaf ID and a running frame number, followed by seven data beats. Backpressure is by valid/ready on both sides.

---
 rtl/leaf_stream_pkg.sv | 22 ++
 rtl/leaf_fifo.sv | 60 ++++++
 rtl/leaf_stream_drain.sv | 172 +++++++++++++++++
 tb/tb_leaf_stream_drain.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/leaf_stream_pkg.sv
// Shared constants and FSM state type for the leaf stream drain.
// Optional checksum beat is enabled with the LEAF_STREAM_CHECKSUM_EN macro.
package leaf_stream_pkg;

  localparam int LEAF_W         = 198;
  localparam int ID_W           = 8;
  localparam int BEAT_W         = 32;
  localparam int CNT_W          = 16;
  localparam int NUM_DATA_BEATS = 7;
  localparam int ENTRY_W        = ID_W + LEAF_W;

  localparam logic [7:0] HDR_MAGIC = 8'hA5;
  localparam logic [2:0] LAST_IDX  = 3'(NUM_DATA_BEATS - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HDR  = 2'd1,
    DATA = 2'd2,
    CSUM = 2'd3
  } state_e;

endpackage

// File: rtl/leaf_fifo.sv
// Synchronous FIFO for {leaf_id, leaf_data} entries.
// Pointers carry an extra wrap bit; full/empty are registered flags so the
// upstream ready depends only on flop outputs.
module leaf_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 206
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_din,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_dout,
  output logic             o_full,
  output logic             o_empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0]      r_wr_ptr;
  logic [AW:0]      r_rd_ptr;
  logic             r_full;
  logic             r_empty;
  logic             w_do_push;
  logic             w_do_pop;
  logic [AW:0]      w_wr_nxt;
  logic [AW:0]      w_rd_nxt;

  assign w_do_push = i_push && !r_full;
  assign w_do_pop  = i_pop && !r_empty;
  assign w_wr_nxt  = r_wr_ptr + (AW+1)'(w_do_push);
  assign w_rd_nxt  = r_rd_ptr + (AW+1)'(w_do_pop);

  assign o_dout  = r_mem[r_rd_ptr[AW-1:0]];
  assign o_full  = r_full;
  assign o_empty = r_empty;

  // Pointer and flag update; flags derived from next-state pointers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_full   <= 1'b0;
      r_empty  <= 1'b1;
    end else begin
      r_wr_ptr <= w_wr_nxt;
      r_rd_ptr <= w_rd_nxt;
      r_full   <= (w_wr_nxt[AW] != w_rd_nxt[AW]) &&
                  (w_wr_nxt[AW-1:0] == w_rd_nxt[AW-1:0]);
      r_empty  <= (w_wr_nxt == w_rd_nxt);
    end
  end

  // Storage write; contents need no reset since pointers gate visibility.
  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr[AW-1:0]] <= i_din;
  end

endmodule

// File: rtl/leaf_stream_drain.sv
// Leaf stream drain: buffers retired leaf matrices and serialises each one as
// a header beat plus seven 32-bit data beats on a valid/ready stream.
// Define LEAF_STREAM_CHECKSUM_EN to append an XOR checksum beat per frame.
module leaf_stream_drain
  import leaf_stream_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          leaf_valid,
  output logic          leaf_ready,
  input  logic [197:0]  leaf_data,
  input  logic [7:0]    leaf_id,
  output logic          m_valid,
  input  logic          m_ready,
  output logic [31:0]   m_data,
  output logic          m_last,
  output logic [15:0]   frame_count,
  output logic          busy
);

`ifdef LEAF_STREAM_CHECKSUM_EN
  localparam bit CSUM_EN = 1'b1;
`else
  localparam bit CSUM_EN = 1'b0;
`endif

  logic               w_full;
  logic               w_empty;
  logic               w_push;
  logic               w_pop;
  logic               w_hs;
  logic               w_final;
  logic [ENTRY_W-1:0] w_fifo_din;
  logic [ENTRY_W-1:0] w_fifo_dout;
  logic [CNT_W-1:0]   w_seq;
  logic [BEAT_W-1:0]  w_hdr;
  logic [2:0]         w_idx_nxt;
  state_e             r_state;
  state_e             w_next;
  logic [2:0]         r_idx;
  logic [LEAF_W-1:0]  r_shift;
  logic               r_m_valid;
  logic [BEAT_W-1:0]  r_m_data;
  logic               r_m_last;
  logic [CNT_W-1:0]   r_frame_count;
`ifdef LEAF_STREAM_CHECKSUM_EN
  logic [BEAT_W-1:0]  r_csum;
`endif

  assign w_push     = leaf_valid && !w_full;
  assign w_fifo_din = {leaf_id, leaf_data};
  assign leaf_ready = !w_full;

  leaf_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (ENTRY_W)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .i_push  (w_push),
    .i_din   (w_fifo_din),
    .i_pop   (w_pop),
    .o_dout  (w_fifo_dout),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  assign w_hs      = r_m_valid && m_ready;
  assign w_final   = w_hs && r_m_last;
  // A header loaded on the final-beat edge must already see the incremented count.
  assign w_seq     = r_frame_count + CNT_W'(w_final);
  assign w_hdr     = {HDR_MAGIC, w_fifo_dout[ENTRY_W-1 -: ID_W], w_seq};
  assign w_idx_nxt = (r_state == DATA) ? (r_idx + 3'd1) : 3'd0;

  assign m_valid     = r_m_valid;
  assign m_data      = r_m_data;
  assign m_last      = r_m_last;
  assign frame_count = r_frame_count;
  assign busy        = !w_empty || (r_state != IDLE);

  // FSM state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next;
  end

  // Next-state and FIFO pop decision; a pop always loads a fresh header.
  always_comb begin
    w_next = r_state;
    w_pop  = 1'b0;
    case (r_state)
      IDLE: begin
        if (!w_empty) begin
          w_pop  = 1'b1;
          w_next = HDR;
        end
      end
      HDR: begin
        if (w_hs) w_next = DATA;
      end
      DATA, CSUM: begin
        if (w_final) begin
          w_pop  = !w_empty;
          w_next = w_empty ? IDLE : HDR;
        end
`ifdef LEAF_STREAM_CHECKSUM_EN
        else if (w_hs && (r_state == DATA) && (r_idx == LAST_IDX)) begin
          w_next = CSUM;
        end
`endif
      end
      default: w_next = IDLE;
    endcase
  end

  // Output beat register, beat index and frame counter; beats hold while stalled.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_m_valid     <= 1'b0;
      r_m_data      <= '0;
      r_m_last      <= 1'b0;
      r_idx         <= 3'd0;
      r_frame_count <= '0;
    end else begin
      if (w_final) r_frame_count <= r_frame_count + 16'd1;
      if (w_pop) begin
        r_m_valid <= 1'b1;
        r_m_data  <= w_hdr;
        r_m_last  <= 1'b0;
        r_idx     <= 3'd0;
      end else if (w_final) begin
        r_m_valid <= 1'b0;
        r_m_last  <= 1'b0;
      end else if (w_hs) begin
        if ((r_state == DATA) && (r_idx == LAST_IDX)) begin
`ifdef LEAF_STREAM_CHECKSUM_EN
          r_m_data <= r_csum;
          r_m_last <= 1'b1;
`endif
        end else begin
          r_m_data <= r_shift[BEAT_W-1:0];
          r_m_last <= (w_idx_nxt == LAST_IDX) && !CSUM_EN;
          r_idx    <= w_idx_nxt;
        end
      end
    end
  end

  // Leaf shift register: low beat is the next data beat to present.
  always_ff @(posedge clk) begin
    if (w_pop) begin
      r_shift <= w_fifo_dout[LEAF_W-1:0];
    end else if (w_hs && ((r_state == HDR) || (r_state == DATA))) begin
      r_shift <= r_shift >> BEAT_W;
    end
  end

`ifdef LEAF_STREAM_CHECKSUM_EN
  // Running XOR of every beat presented so far in the frame.
  always_ff @(posedge clk) begin
    if (w_pop) begin
      r_csum <= w_hdr;
    end else if (w_hs && ((r_state == HDR) ||
                          ((r_state == DATA) && (r_idx != LAST_IDX)))) begin
      r_csum <= r_csum ^ r_shift[BEAT_W-1:0];
    end
  end
`endif

endmodule

// File: tb/tb_leaf_stream_drain.sv
// Bench for leaf_stream_drain: directed stimulus with a beat scoreboard.
// Honours LEAF_STREAM_CHECKSUM_EN for the expected frame layout.
module tb_leaf_stream_drain;

  typedef struct packed {
    logic [31:0] data;
    logic        last;
  } beat_t;

  logic         clk = 1'b0;
  logic         reset;
  logic         leaf_valid;
  logic         leaf_ready;
  logic [197:0] leaf_data;
  logic [7:0]   leaf_id;
  logic         m_valid;
  logic         m_ready;
  logic [31:0]  m_data;
  logic         m_last;
  logic [15:0]  frame_count;
  logic         busy;

  beat_t        exp_q[$];
  logic [15:0]  model_seq;
  int           n_tests = 0;
  int           n_fail  = 0;
  bit           gap_chk = 1'b0;
  bit           prev_stall = 1'b0;
  bit           prev_last_hs = 1'b0;
  logic [31:0]  prev_data;
  logic         prev_last;

  leaf_stream_drain #(.FIFO_DEPTH(4)) dut (
    .clk         (clk),
    .reset       (reset),
    .leaf_valid  (leaf_valid),
    .leaf_ready  (leaf_ready),
    .leaf_data   (leaf_data),
    .leaf_id     (leaf_id),
    .m_valid     (m_valid),
    .m_ready     (m_ready),
    .m_data      (m_data),
    .m_last      (m_last),
    .frame_count (frame_count),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Queue the full expected frame for one accepted leaf.
  task automatic add_expected(input logic [197:0] d, input logic [7:0] id);
    beat_t       b;
    logic [31:0] cs;
    logic [197:0] t;
    b.data = {8'hA5, id, model_seq};
    b.last = 1'b0;
    exp_q.push_back(b);
    cs = b.data;
    for (int k = 0; k < 7; k++) begin
      t      = d >> (32 * k);
      b.data = t[31:0];
`ifdef LEAF_STREAM_CHECKSUM_EN
      b.last = 1'b0;
`else
      b.last = (k == 6);
`endif
      cs = cs ^ b.data;
      exp_q.push_back(b);
    end
`ifdef LEAF_STREAM_CHECKSUM_EN
    b.data = cs;
    b.last = 1'b1;
    exp_q.push_back(b);
`endif
    model_seq = model_seq + 16'd1;
  endtask

  // Offer one leaf (called just after a rising edge); returns just after acceptance edge.
  task automatic push_leaf(input logic [197:0] d, input logic [7:0] id);
    int waited = 0;
    leaf_valid = 1'b1;
    leaf_data  = d;
    leaf_id    = id;
    @(negedge clk);
    while (!leaf_ready && waited < 200) begin
      @(negedge clk);
      waited++;
    end
    if (!leaf_ready) chk("push_timeout", 32'(leaf_ready), 32'd1);
    else add_expected(d, id);
    @(posedge clk);
    #1 leaf_valid = 1'b0;
  endtask

  // Run until every expected beat is consumed, optionally toggling m_ready.
  task automatic wait_drain(input bit tog);
    int n = 0;
    while (exp_q.size() != 0 && n < 3000) begin
      @(posedge clk);
      #1;
      if (tog) m_ready = !m_ready;
      @(negedge clk);
      n++;
    end
    chk("drain_timeout", 32'(exp_q.size()), 32'd0);
    @(posedge clk);
    #1 m_ready = 1'b1;
    @(negedge clk);
    chk("idle_m_valid", 32'(m_valid), 32'd0);
    chk("idle_busy", 32'(busy), 32'd0);
    chk("frame_count", 32'(frame_count), 32'(model_seq));
  endtask

  // Output monitor: scoreboard compare, stall stability and back-to-back framing.
  always @(negedge clk) begin
    beat_t e;
    if (reset) begin
      prev_stall   = 1'b0;
      prev_last_hs = 1'b0;
    end else begin
      if (prev_stall) begin
        chk("hold_valid", 32'(m_valid), 32'd1);
        chk("hold_data", m_data, prev_data);
        chk("hold_last", 32'(m_last), 32'(prev_last));
      end
      if (gap_chk && prev_last_hs && exp_q.size() > 0)
        chk("no_bubble", 32'(m_valid), 32'd1);
      prev_last_hs = 1'b0;
      if (m_valid && m_ready) begin
        if (exp_q.size() == 0) begin
          chk("spurious_beat", 32'(exp_q.size()), 32'd1);
        end else begin
          e = exp_q.pop_front();
          chk("beat_data", m_data, e.data);
          chk("beat_last", 32'(m_last), 32'(e.last));
          if (m_last) prev_last_hs = 1'b1;
        end
      end
      prev_stall = m_valid && !m_ready;
      prev_data  = m_data;
      prev_last  = m_last;
    end
  end

  initial begin
    logic [197:0] d;
    reset      = 1'b1;
    leaf_valid = 1'b0;
    leaf_data  = '0;
    leaf_id    = '0;
    m_ready    = 1'b1;
    model_seq  = 16'd0;

    // Reset values
    #12;
    chk("rst_m_valid", 32'(m_valid), 32'd0);
    chk("rst_m_data", m_data, 32'd0);
    chk("rst_m_last", 32'(m_last), 32'd0);
    chk("rst_frame_count", 32'(frame_count), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_leaf_ready", 32'(leaf_ready), 32'd1);
    @(posedge clk);
    #1 reset = 1'b0;
    @(posedge clk);
    #1;

    // Single leaf: bits 197 and 0 set, id 03
    d = '0;
    d[197] = 1'b1;
    d[0]   = 1'b1;
    push_leaf(d, 8'h03);
    @(negedge clk);
    chk("lat_no_hdr_yet", 32'(m_valid), 32'd0);
    chk("lat_busy", 32'(busy), 32'd1);
    @(negedge clk);
    chk("lat_hdr_valid", 32'(m_valid), 32'd1);
    chk("lat_hdr_data", m_data, 32'hA5030000);
    wait_drain(1'b0);
    chk("single_count", 32'(frame_count), 32'd1);

    // Backpressure: two frames with m_ready toggling every cycle
    @(posedge clk);
    #1 m_ready = 1'b0;
    push_leaf({6'h15, {6{32'hDEAD_0000 | 32'($urandom_range(0, 65535))}}}, 8'h11);
    push_leaf({6'h2A, 32'h0101_0101, 32'h0202_0202, 32'h0303_0303,
               32'h0404_0404, 32'h0505_0505, 32'h0606_0606}, 8'h22);
    wait_drain(1'b1);

    // Fill: one leaf sits in the output stage, so FIFO_DEPTH+1 leaves are absorbed
    @(posedge clk);
    #1 m_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      d = {6'(i), {6{32'($urandom)}}};
      push_leaf(d, 8'(8'h40 + i));
    end
    @(negedge clk);
    chk("full_leaf_ready", 32'(leaf_ready), 32'd0);
    chk("full_busy", 32'(busy), 32'd1);
    @(posedge clk);
    #1 leaf_valid = 1'b1;
    leaf_data = '1;
    leaf_id   = 8'hEE;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("full_reject", 32'(leaf_ready), 32'd0);
    end
    @(posedge clk);
    #1 leaf_valid = 1'b0;
    gap_chk = 1'b1;
    m_ready = 1'b1;
    wait_drain(1'b0);
    gap_chk = 1'b0;

    // Frame counter wrap: FFFE, FFFF, then 0000
    @(negedge clk);
    force dut.r_frame_count = 16'hFFFE;
    @(negedge clk);
    release dut.r_frame_count;
    model_seq = 16'hFFFE;
    @(posedge clk);
    #1;
    push_leaf({6'h01, {6{32'hCAFE_F00D}}}, 8'h70);
    push_leaf({6'h02, {6{32'h1234_5678}}}, 8'h71);
    wait_drain(1'b0);
    chk("wrap_to_zero", 32'(frame_count), 32'd0);
    @(posedge clk);
    #1;
    push_leaf({6'h03, {6{32'h8765_4321}}}, 8'h72);
    wait_drain(1'b0);

    // Mid-frame reset while D3 is on the bus, with another leaf queued
    @(posedge clk);
    #1 m_ready = 1'b0;
    push_leaf({6'h3F, 32'h6666_6666, 32'h5555_5555, 32'h4444_4444,
               32'h3333_3333, 32'h2222_2222, 32'h1111_1111}, 8'h55);
    @(posedge clk);
    #1 m_ready = 1'b1;
    repeat (4) @(posedge clk);
    #1 m_ready = 1'b0;
    @(negedge clk);
    chk("pre_reset_d3", m_data, exp_q[0].data);
    @(posedge clk);
    #1;
    push_leaf({6'h0F, {6{32'hABCD_EF01}}}, 8'h56);
    reset = 1'b1;
    #1;
    chk("mid_rst_m_valid", 32'(m_valid), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_leaf_ready", 32'(leaf_ready), 32'd1);
    chk("mid_rst_frame_count", 32'(frame_count), 32'd0);
    exp_q.delete();
    model_seq = 16'd0;
    @(negedge clk);
    @(posedge clk);
    #1 reset = 1'b0;
    m_ready = 1'b1;
    @(posedge clk);
    #1;
    push_leaf({6'h21, {6{32'h0BAD_BEEF}}}, 8'h99);
    wait_drain(1'b0);
    chk("post_rst_count", 32'(frame_count), 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
